// File: rtl/lsu_mem_master.sv
// Load/store unit driving the CPU data-memory port; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses are rejected with resp_err.
module lsu_mem_master #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wlane_q;
  logic [31:0] mwdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        req_sw;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;
  assign req_sw = req_we && (req_funct3 == 3'b010);

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 != 3'b000 && req_funct3 != 3'b001 && req_funct3 != 3'b010)
        req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
        req_err = 1'b1;
    end
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
      req_err = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  // Lane extraction for loads, taken straight from mem_rdata during CAP only
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = mem_rdata;
      3'b100:  rd_ext = {24'h000000, rd_byte};
      3'b101:  rd_ext = {16'h0000, rd_half};
      default: rd_ext = '0;
    endcase
  end

  // RMW merge: replicate the new lane across the word, then keep only the masked bits
  always_comb begin
    if (f3_q[0]) begin
      mask      = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lane_data = {2{wlane_q}};
    end else begin
      mask      = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      lane_data = {4{wlane_q[7:0]}};
    end
    merged = (mem_rdata & ~mask) | (lane_data & mask);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)     state_nx = RESP;
        else if (req_sw) state_nx = WR;
        else             state_nx = RD;
      end
      RD:      state_nx = CAP;
      CAP:     state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wlane_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        f3_q     <= req_funct3;
        addr_q   <= req_addr;
        wlane_q  <= req_wdata[15:0];
        mwdata_q <= req_sw ? req_wdata : '0;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state == CAP) begin
        if (we_q) mwdata_q <= merged;
        else      rdata_q  <= rd_ext;
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_read   = (state == RD);
    mem_write  = (state == WR);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = (state == RESP) ? rdata_q : '0;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = mwdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: vector table through a response scoreboard, plus reset corner cases.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_master #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered memory: read data is meaningful only in the cycle after mem_read
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = '0;
  logic        rd_valid = 1'b0;
  always @(posedge clk) begin
    rd_valid <= mem_read;
    if (mem_read)  rd_q <= mem[mem_addr[11:2]];
    if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  end
  assign mem_rdata = rd_valid ? rd_q : (~rd_q ^ 32'h5A5A_A5A5);

`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mwdata;
    int unsigned lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned nrd = 0;
  int unsigned nwr = 0;
  logic [31:0] exp_maddr = '0;
  logic [31:0] exp_mw = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic e, logic [31:0] rd, logic [31:0] mw, int unsigned lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.err = e; v.rdata = rd; v.mwdata = mw; v.lat = lat;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) chk("mem_addr", mem_addr, exp_maddr);
      if (mem_write) chk("mem_wdata", mem_wdata, exp_mw);
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned r0, w0, er, ew;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    er = (v.err || (v.we && v.f3 == 3'b010)) ? 0 : 1;
    ew = (!v.err && v.we) ? 1 : 0;
    exp_maddr = {v.addr[31:2], 2'b00};
    exp_mw    = v.mwdata;
    r0 = nrd; w0 = nwr;
    sb_q.push_back('{err: v.err, rdata: v.rdata, cyc: cyc + v.lat});
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got no response expected one within 20 cycles (t=%0t)", $time);
      sb_q.delete();
    end
    chk("rd_strobes", nrd - r0, er);
    chk("wr_strobes", nwr - w0, ew);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_read"},   {31'b0, mem_read},   32'd0);
    chk({tag, "_mem_write"},  {31'b0, mem_write},  32'd0);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
    chk({tag, "_mem_addr"},   mem_addr,   32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,  32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    //              we    f3      addr           wdata          err   rdata          mwdata         lat
    vecs.push_back(mk(1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 2));
    vecs.push_back(mk(1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        3));
    vecs.push_back(mk(1'b1, 3'b010, 32'h20,   32'h11223344, 1'b0, 32'h0,        32'h11223344, 2));
    vecs.push_back(mk(1'b1, 3'b000, 32'h21,   32'hFFFFFFAA, 1'b0, 32'h0,        32'h1122AA44, 4));
    vecs.push_back(mk(1'b0, 3'b000, 32'h21,   32'h0,        1'b0, 32'hFFFFFFAA, 32'h0,        3));
    vecs.push_back(mk(1'b0, 3'b100, 32'h21,   32'h0,        1'b0, 32'h000000AA, 32'h0,        3));
    vecs.push_back(mk(1'b1, 3'b010, 32'h30,   32'h80017FFF, 1'b0, 32'h0,        32'h80017FFF, 2));
    vecs.push_back(mk(1'b0, 3'b001, 32'h32,   32'h0,        1'b0, 32'hFFFF8001, 32'h0,        3));
    vecs.push_back(mk(1'b0, 3'b101, 32'h32,   32'h0,        1'b0, 32'h00008001, 32'h0,        3));
    vecs.push_back(mk(1'b0, 3'b001, 32'h30,   32'h0,        1'b0, 32'h00007FFF, 32'h0,        3));
    vecs.push_back(mk(1'b1, 3'b001, 32'h32,   32'hABCD1234, 1'b0, 32'h0,        32'h12347FFF, 4));
    vecs.push_back(mk(1'b0, 3'b010, 32'h30,   32'h0,        1'b0, 32'h12347FFF, 32'h0,        3));
    vecs.push_back(mk(1'b0, 3'b010, 32'h1000, 32'h0,        1'b1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1'b0, 3'b011, 32'h10,   32'h0,        1'b1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1'b1, 3'b100, 32'h10,   32'h12345678, 1'b1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1'b1, 3'b010, 32'hFFC,  32'hCAFEF00D, 1'b0, 32'h0,        32'hCAFEF00D, 2));
    vecs.push_back(mk(1'b0, 3'b010, 32'hFFC,  32'h0,        1'b0, 32'hCAFEF00D, 32'h0,        3));
    vecs.push_back(mk(1'b1, 3'b000, 32'h23,   32'h00000055, 1'b0, 32'h0,        32'h5522AA44, 4));
    vecs.push_back(mk(1'b0, 3'b000, 32'h23,   32'h0,        1'b0, 32'h00000055, 32'h0,        3));
    vecs.push_back(mk(1'b0, 3'b010, 32'h13,   32'h0,        MIS, MIS ? 32'h0 : 32'hDEADBEEF,
                      32'h0, MIS ? 1 : 3));
    vecs.push_back(mk(1'b0, 3'b101, 32'h33,   32'h0,        MIS, MIS ? 32'h0 : 32'h00001234,
                      32'h0, MIS ? 1 : 3));
    vecs.push_back(mk(1'b1, 3'b001, 32'h31,   32'hFFFF5678, MIS, 32'h0,        32'h12345678,
                      MIS ? 1 : 4));
    vecs.push_back(mk(1'b0, 3'b010, 32'h30,   32'h0,        1'b0, MIS ? 32'h12347FFF : 32'h12345678,
                      32'h0, 3));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during CAP of an SB: the pending write must never reach memory
    exp_maddr = 32'h20; exp_mw = 32'h5522AA77;
    w0 = nwr;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_rd_phase", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", {31'b0, req_ready}, 32'd1);
    chk("no_write_after_reset", nwr - w0, 32'd0);
    run_vec(mk(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h5522AA44, 32'h0, 3));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
